// File: rtl/opl2_pkg.sv
// Shared OPL2 register-bus types and constants used by host_if, timers and other register consumers.
package opl2_pkg;

    localparam int unsigned REG_FILE_DATA_WIDTH        = 8;
    localparam int unsigned REG_FILE_ADDR_WIDTH        = 8;
    localparam int unsigned HOST_DATA_WIDTH            = 8;
    localparam int unsigned HOST_IF_FIFO_DEPTH_DEFAULT = 8;
    localparam int unsigned REG_WR_PAYLOAD_WIDTH       = REG_FILE_ADDR_WIDTH + REG_FILE_DATA_WIDTH;

    typedef struct packed {
        logic                           valid;
        logic [REG_FILE_ADDR_WIDTH-1:0] address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } opl2_reg_wr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } host_if_state_t;

endpackage

// File: rtl/reg_wr_fifo.sv
// Single-clock FIFO buffering {address, data} register writes between host and issue logic.
module reg_wr_fifo
    import opl2_pkg::*;
#(
    parameter int unsigned DEPTH = HOST_IF_FIFO_DEPTH_DEFAULT,
    parameter int unsigned WIDTH = REG_WR_PAYLOAD_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_next;

    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/host_if.sv
// OPL2 host port front end: address latch, buffered data writes, paced register-write issue, status reads.
// Optional HOST_IF_WR_SPACING_EN enforces WR_SPACING idle cycles between issued writes.
module host_if
    import opl2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = HOST_IF_FIFO_DEPTH_DEFAULT,
    parameter int unsigned WR_SPACING = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           host_wr,
    input  logic                           host_rd,
    input  logic                           host_a0,
    input  logic [HOST_DATA_WIDTH-1:0]     host_din,
    output logic [HOST_DATA_WIDTH-1:0]     host_dout,
    input  logic [REG_FILE_DATA_WIDTH-1:0] status,
    output opl2_reg_wr_t                   opl2_reg_wr,
    output logic                           fifo_full,
    output logic                           overflow
);

    localparam int unsigned HOST_W = HOST_DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PAY_W  = REG_WR_PAYLOAD_WIDTH;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("host_if: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (WR_SPACING > 65535) begin : g_bad_spacing
        $error("host_if: WR_SPACING must fit a 16-bit spacing counter");
    end

    host_if_state_t                 state;
    host_if_state_t                 next_state;
    logic [REG_FILE_ADDR_WIDTH-1:0] addr_latch;
    logic                           addr_wr;
    logic                           data_wr;
    logic                           rd_en;
    logic                           fifo_pop;
    logic                           fifo_empty;
    logic [PAY_W-1:0]               fifo_head;
    logic [CNT_W-1:0]               fifo_count;
    logic                           unused_count;
    logic                           gap_last;

    // A write strobe wins over a read strobe in the same cycle.
    assign addr_wr = host_wr && !host_a0;
    assign data_wr = host_wr && host_a0;
    assign rd_en   = host_rd && !host_wr;

    // Occupancy is only kept for debug visibility.
    assign unused_count = ^fifo_count;

    reg_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_wr),
        .pop   (fifo_pop),
        .din   ({addr_latch, host_din}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef HOST_IF_WR_SPACING_EN
    localparam int unsigned GAP_W   = (WR_SPACING > 0) ? $clog2(WR_SPACING + 1) : 1;
    localparam bit          USE_GAP = (WR_SPACING != 0);

    logic [GAP_W-1:0] gap_cnt;

    // Loaded while a write is on the bus, then counted down through the GAP cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            gap_cnt <= GAP_W'(WR_SPACING);
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    assign gap_last = (gap_cnt == GAP_W'(1));
`else
    localparam bit USE_GAP = 1'b0;

    assign gap_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) next_state = ST_ISSUE;
            ST_ISSUE: next_state = USE_GAP ? ST_GAP : (fifo_empty ? ST_IDLE : ST_ISSUE);
            ST_GAP:   if (gap_last) next_state = fifo_empty ? ST_IDLE : ST_ISSUE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // The head leaves the FIFO on the edge that puts it on the bus.
    always_comb begin
        fifo_pop = 1'b0;
        if (next_state == ST_ISSUE) fifo_pop = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opl2_reg_wr <= '0;
        end else begin
            opl2_reg_wr.valid <= fifo_pop;
            if (fifo_pop) {opl2_reg_wr.address, opl2_reg_wr.data} <= fifo_head;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_latch <= '0;
            host_dout  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (addr_wr) addr_latch <= host_din;
            if (rd_en)   host_dout  <= host_a0 ? HOST_W'(8'hFF) : HOST_W'(status);
            if (data_wr && fifo_full && !fifo_pop) overflow <= 1'b1;
        end
    end

endmodule

// File: doc/host_if.md
# host_if

Host-side register write front end for the OPL2 core, in the `clk` domain. It sits directly upstream of the timers and the rest of the register consumers. It decodes the two-port OPL2 host protocol (address port, data port) into `opl2_reg_wr` transactions and buffers bursts of data writes in a small FIFO. It then issues those writes with an optional minimum spacing and returns the timer status byte on host reads.

## Interface
- `FIFO_DEPTH`, default 8: write FIFO entries; must be a power of two and at least 2.
- `WR_SPACING`, default 3: idle cycles enforced between consecutive `opl2_reg_wr.valid` pulses. Used only with `HOST_IF_WR_SPACING_EN`.
- `clk`  in  1  core clock.
- `reset`  in  1  reset; synchronous, active-high. Clock is `clk`.
- `host_wr`  in  1  single-cycle write strobe, already synchronized to `clk`.
- `host_rd`  in  1  single-cycle read strobe, already synchronized to `clk`.
- `host_a0`  in  1  port select: 0 = address/status port, 1 = data port.
- `host_din`  in  8  write data.
- `host_dout`  out  8  registered read data.
- `status`  in  `REG_FILE_DATA_WIDTH`  status byte from timers.
- `opl2_reg_wr`  out  `opl2_reg_wr_t`  register write: `valid`, `address`, `data`.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `overflow`  out  1  sticky flag; set when a data write is dropped.

## Operation
- Address write (`host_wr`, `host_a0`=0): `host_din` is loaded into the address latch on that edge. Nothing is queued.
- Data write (`host_wr`, `host_a0`=1): {address latch, `host_din`} is pushed into the FIFO. The address latch is unchanged, so repeated data writes reuse the same address.
- Push while full:
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise the write is dropped and `overflow` is set. `overflow` clears only on reset.
- `host_wr` and `host_rd` high in the same cycle: the write is performed and the read is ignored; `host_dout` holds its value.
- Read (`host_rd`):
  - `host_a0`=0: `host_dout` is loaded with `status`.
  - `host_a0`=1: `host_dout` is loaded with 8'hFF.
  - With no read, `host_dout` holds its value.
- Issue FSM states:
  - IDLE: FIFO empty or spacing done. Goes to ISSUE when the FIFO is non-empty.
  - ISSUE: `valid`=1 for exactly one cycle with the head entry, and the head is popped. The spacing counter loads `WR_SPACING`. Goes to GAP if `WR_SPACING`>0, else to ISSUE (FIFO non-empty) or IDLE.
  - GAP: counter decrements each cycle. At zero it goes to ISSUE (FIFO non-empty) or IDLE.
- `opl2_reg_wr.address`/`data` are held stable while `valid` is low; they are don't-care.
- Reset values:
  - `opl2_reg_wr.valid`=0, `address`=0, `data`=0.
  - `host_dout`=0, `fifo_full`=0, `overflow`=0.
  - Address latch=0, FIFO empty, FSM IDLE, counter 0.
- Reset mid-burst flushes all queued writes; no further `valid` pulse appears from pre-reset data.

## Timing
- Data write strobe in cycle c with FIFO empty and FSM IDLE: `valid` is high in cycle c+2.
- Address write in cycle c followed by a data write in cycle c+1: the data write uses the new address.
- `valid` in cycle p: the next `valid` comes no earlier than p+1+`WR_SPACING` (`HOST_IF_WR_SPACING_EN` defined).
- Read strobe in cycle c: `host_dout` is valid from cycle c+1 and reflects `status` as sampled in cycle c.
- `fifo_full` and `overflow` are registered and update one cycle after the causing edge.
- Occupancy counter width is $clog2(`FIFO_DEPTH`+1). Read/write pointers wrap modulo `FIFO_DEPTH`.

## Configuration
- `HOST_IF_WR_SPACING_EN` defined: GAP state and spacing counter exist; `WR_SPACING` is enforced.
- Undefined: no GAP state and no counter. ISSUE goes directly back to ISSUE/IDLE, draining one entry per cycle. `WR_SPACING` is ignored.

## Structure
- `opl2_pkg`:
  - `opl2_reg_wr_t`, `REG_FILE_DATA_WIDTH` and the register address width, shared with timers.
  - New `HOST_IF_FIFO_DEPTH_DEFAULT` constant.
  - FSM state enum `host_if_state_t`.
- One sub-module, `reg_wr_fifo`: synchronous single-clock FIFO.
  - Signals: push, pop, head, full, empty, count.
  - Width parameterized to the `opl2_reg_wr_t` payload.
- Top level holds the address latch, read mux, issue FSM, spacing counter and overflow flag.

## Test plan
- Address write 8'h04, then data write 8'h80 → one `valid` with address=8'h04, data=8'h80 in cycle c+2 after the data strobe.
- Address write 8'h02, then data writes 8'h11, 8'h22, 8'h33 back-to-back, `WR_SPACING`=3 → three `valid` pulses with spacing of exactly 4 cycles, all address 8'h02, data in order.
- 10 data writes with `FIFO_DEPTH`=8 and the FSM held in GAP → `fifo_full`=1, `overflow`=1, and exactly 8 writes emitted in order.
- `status`=8'hE0 with a read at `host_a0`=0 → `host_dout`=8'hE0 next cycle; a read at `host_a0`=1 → 8'hFF.
- Reset asserted with 5 entries queued → `valid`=0 from the next cycle and no further pulses. `overflow`=0, and a following data write uses address 8'h00.
- Build without `HOST_IF_WR_SPACING_EN` and 4 queued writes → `valid` high for 4 consecutive cycles.
